// File: rtl/reg16b_wr_arbiter.sv
// reg16b_wr_arbiter: shares write access to a bank of reg16b registers among NREQ requesters.
// Round-robin arbitration by default; define ARB_FIXED_PRIO_EN for fixed lowest-index priority.
// Each grant spends one IDLE cycle selecting and one WRITE cycle driving reg_d/reg_en/ack.
`timescale 1ns/1ps

module reg16b_wr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned NREG = 8,
  parameter int unsigned AW   = 3,
  parameter int unsigned DW   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*AW-1:0]      wr_addr,
  input  logic [NREQ*DW-1:0]      wr_data,
  output logic [NREQ-1:0]         ack,
  output logic [DW-1:0]           reg_d,
  output logic [NREG-1:0]         reg_en,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] gnt_id
);

  localparam int unsigned IW = $clog2(NREQ);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr, ptr_nxt;
  logic [IW-1:0]   gnt_nxt;
  logic [IW-1:0]   win, cand;
  logic            found;
  logic [AW-1:0]   win_addr;
  logic [NREQ-1:0] ack_nxt;
  logic [NREG-1:0] reg_en_nxt;
  logic [DW-1:0]   reg_d_nxt;
  logic            busy_nxt;

  // Winner search: first set req scanning upward from the priority pointer with wrap.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
`ifdef ARB_FIXED_PRIO_EN
      cand = IW'(i);
`else
      cand = IW'((32'(ptr) + i) % NREQ);
`endif
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    win_addr = wr_addr[32'(win)*AW +: AW];
  end

  // Next-state and next-output decode; outputs are registered so req never reaches them combinationally.
  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    gnt_nxt    = gnt_id;
    ack_nxt    = '0;
    reg_en_nxt = '0;
    reg_d_nxt  = reg_d;
    busy_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt    = WRITE;
          gnt_nxt      = win;
          busy_nxt     = 1'b1;
          reg_d_nxt    = wr_data[32'(win)*DW +: DW];
          ack_nxt[win] = 1'b1;
          // Out-of-range addresses match no bit, so the write is dropped but still acked.
          for (int unsigned j = 0; j < NREG; j++) begin
            reg_en_nxt[j] = (win_addr == AW'(j));
          end
        end
      end
      WRITE: begin
        state_nxt = IDLE;
`ifdef ARB_FIXED_PRIO_EN
        ptr_nxt   = '0;
`else
        ptr_nxt   = IW'((32'(gnt_id) + 32'd1) % NREQ);
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      gnt_id <= '0;
      ack    <= '0;
      reg_en <= '0;
      reg_d  <= '0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      gnt_id <= gnt_nxt;
      ack    <= ack_nxt;
      reg_en <= reg_en_nxt;
      reg_d  <= reg_d_nxt;
      busy   <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_reg16b_wr_arbiter.sv
// Testbench for reg16b_wr_arbiter: randomized and directed requester traffic, scoreboard-checked.
`timescale 1ns/1ps

module tb_reg16b_wr_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned NREG = 6;
  localparam int unsigned AW   = 3;
  localparam int unsigned DW   = 16;
  localparam int unsigned IW   = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [NREQ-1:0]      req;
  logic [NREQ*AW-1:0]   wr_addr;
  logic [NREQ*DW-1:0]   wr_data;
  logic [NREQ-1:0]      ack;
  logic [DW-1:0]        reg_d;
  logic [NREG-1:0]      reg_en;
  logic                 busy;
  logic [IW-1:0]        gnt_id;

  reg16b_wr_arbiter #(.NREQ(NREQ), .NREG(NREG), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .wr_addr(wr_addr), .wr_data(wr_data),
    .ack(ack), .reg_d(reg_d), .reg_en(reg_en), .busy(busy), .gnt_id(gnt_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              id;
    logic [NREQ-1:0] ack;
    logic [NREG-1:0] en;
    logic [DW-1:0]   d;
    int              due;
  } exp_t;

  exp_t          q[$];
  exp_t          mon_e;
  int            nvec = 0;
  int            nerr = 0;
  int            cyc  = 0;
  bit            mon_on = 1'b0;
  logic [DW-1:0] last_d = '0;

  // Requester-side view and reference model state
  bit            rq[NREQ];
  logic [AW-1:0] ad[NREQ];
  logic [DW-1:0] dt[NREQ];
  bit            keep[NREQ];
  int            m_ptr = 0;
  bit            m_write = 1'b0;
  int            m_w = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      req[i]             = rq[i];
      wr_addr[i*AW +: AW] = ad[i];
      wr_data[i*DW +: DW] = dt[i];
    end
  endtask

  // Round-robin: first pending requester at or after the pointer, wrapping around
  function automatic int pick();
    int p;
`ifdef ARB_FIXED_PRIO_EN
    p = 0;
`else
    p = m_ptr;
`endif
    for (int k = 0; k < NREQ; k++) begin
      if (rq[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // Called just after a falling edge: model the next rising edge and drive inputs
  task automatic drive_and_model();
    int   w;
    exp_t e;
    if (m_write) begin
      m_write = 1'b0;
      if (!keep[m_w]) rq[m_w] = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
      m_ptr = 0;
`else
      m_ptr = (m_w + 1) % NREQ;
`endif
    end else begin
      w = pick();
      if (w >= 0) begin
        e.id  = w;
        e.ack = NREQ'(1) << w;
        e.en  = (32'(ad[w]) < NREG) ? (NREG'(1) << ad[w]) : '0;
        e.d   = dt[w];
        e.due = cyc + 1;
        q.push_back(e);
        m_write = 1'b1;
        m_w     = w;
      end
    end
    apply();
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      drive_and_model();
    end
  endtask

  // Monitor: compare each ack cycle against the scoreboard, and idle cycles against quiet outputs
  always @(negedge clk) begin
    if (mon_on && !rst) begin
      if (ack != '0) begin
        if (q.size() == 0) begin
          chk("unexpected_ack", 32'(ack), 32'd0);
        end else begin
          mon_e = q.pop_front();
          chk("ack", 32'(ack), 32'(mon_e.ack));
          chk("reg_en", 32'(reg_en), 32'(mon_e.en));
          chk("reg_d", 32'(reg_d), 32'(mon_e.d));
          chk("gnt_id", 32'(gnt_id), 32'(mon_e.id));
          chk("busy_write", 32'(busy), 32'd1);
          last_d = mon_e.d;
        end
      end else begin
        chk("idle_reg_en", 32'(reg_en), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_reg_d_hold", 32'(reg_d), 32'(last_d));
        if (q.size() != 0 && q[0].due < cyc) begin
          chk("missing_ack", 32'(ack), 32'(q[0].ack));
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack"}, 32'(ack), 32'd0);
    chk({tag, "_reg_en"}, 32'(reg_en), 32'd0);
    chk({tag, "_reg_d"}, 32'(reg_d), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_gnt_id"}, 32'(gnt_id), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      rq[i] = 1'b0; ad[i] = '0; dt[i] = '0; keep[i] = 1'b0;
    end
    apply();
    #1 rst = 1'b1;
    #2 chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mon_on = 1'b1;
    run(3);

    // Contention: all four request at once, each dropping after its ack
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      rq[i] = 1'b1; ad[i] = AW'(i + 1); dt[i] = DW'(16'h1000 + i);
    end
    drive_and_model();
    run(10);

    // Single write to register 5
    @(negedge clk);
    rq[0] = 1'b1; ad[0] = 3'd5; dt[0] = 16'hA5A5;
    drive_and_model();
    run(4);

    // Fairness: req0 and req2 both re-request immediately after each ack
    @(negedge clk);
    rq[0] = 1'b1; ad[0] = 3'd1; dt[0] = 16'h0F0F; keep[0] = 1'b1;
    rq[2] = 1'b1; ad[2] = 3'd3; dt[2] = 16'h2222; keep[2] = 1'b1;
    drive_and_model();
    run(8);
    @(negedge clk);
    keep[0] = 1'b0; keep[2] = 1'b0;
    drive_and_model();
    run(8);

    // Out-of-range addresses: acked, no enable
    @(negedge clk);
    rq[1] = 1'b1; ad[1] = 3'd7; dt[1] = 16'h1234;
    rq[3] = 1'b1; ad[3] = 3'd6; dt[3] = 16'h5678;
    drive_and_model();
    run(6);

    // Reset during the WRITE cycle, then a full contention round starting from req0
    @(negedge clk);
    rq[3] = 1'b1; ad[3] = 3'd2; dt[3] = 16'hBEEF;
    drive_and_model();
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    m_write = 1'b0;
    m_ptr   = 0;
    last_d  = '0;
    #1 chk_reset_outputs("rst_in_write");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      rq[i] = 1'b1; ad[i] = AW'(i); dt[i] = DW'(16'hC000 + i);
    end
    drive_and_model();
    run(10);

    // Randomized traffic
    repeat (600) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (!rq[i]) begin
          if ($urandom_range(3) == 0) begin
            rq[i]   = 1'b1;
            ad[i]   = AW'($urandom_range(7));
            dt[i]   = DW'($urandom);
            keep[i] = ($urandom_range(3) == 0);
          end
        end else if ($urandom_range(15) == 0) begin
          rq[i] = 1'b0;
        end else if ($urandom_range(7) == 0) begin
          ad[i] = AW'($urandom_range(7));
          dt[i] = DW'($urandom);
        end
      end
      drive_and_model();
    end

    // Drain
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      rq[i] = 1'b0; keep[i] = 1'b0;
    end
    drive_and_model();
    run(6);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
